// File: rtl/ftoi.sv
// Pipelined IEEE-754 binary32 to signed 32-bit integer converter.
// Rounds half away from zero and saturates; fixed 2-cycle latency, no backpressure.
module ftoi (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic        in_valid,
    output logic [31:0] y,
    output logic        out_valid,
    output logic        ovf
);

    // Returns {31-bit pre-round magnitude, round bit} for a finite in-range exponent.
    function automatic logic [31:0] f_denorm(input logic [7:0] e, input logic [23:0] sig);
        logic [24:0] ext;
        logic [30:0] left;
        logic [4:0]  rsh;
        logic [2:0]  lsh;
        ext      = '0;
        left     = '0;
        rsh      = '0;
        lsh      = '0;
        f_denorm = '0;
        if (e >= 8'd126 && e <= 8'd150) begin
            // Appending a zero LSB lets the last bit shifted out land in ext[0].
            rsh      = 5'(8'd150 - e);
            ext      = {sig, 1'b0} >> rsh;
            f_denorm = {7'd0, ext};
        end else if (e >= 8'd151 && e <= 8'd157) begin
            lsh      = 3'(e - 8'd150);
            left     = {7'd0, sig} << lsh;
            f_denorm = {left, 1'b0};
        end
    endfunction

    function automatic logic signed [31:0] f_round(input logic sign, input logic [30:0] mag,
                                                   input logic rb);
        logic signed [31:0] rmag;
        rmag    = signed'({1'b0, mag} + {31'd0, rb});
        f_round = sign ? -rmag : rmag;
    endfunction

    function automatic logic signed [31:0] f_saturate(input logic neg);
        f_saturate = neg ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    endfunction

    logic [7:0]  w_exp;
    logic [31:0] w_dn;
    logic        w_sat;
    logic        w_min_int;

    assign w_exp     = x[30:23];
    assign w_dn      = f_denorm(w_exp, {1'b1, x[22:0]});
    assign w_sat     = (w_exp >= 8'd158);
    assign w_min_int = (x == 32'hCF00_0000);

    logic               r_sign_p1;
    logic [30:0]        r_mag_p1;
    logic               r_rb_p1;
    logic               r_sat_p1;
    logic               r_satsel_p1;
    logic               r_satovf_p1;
    logic               r_vld_p1;
    logic signed [31:0] r_y_p2;
    logic               r_ovf_p2;
    logic               r_vld_p2;

    // Stage 1: unpack and denormalise
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sign_p1   <= 1'b0;
            r_mag_p1    <= '0;
            r_rb_p1     <= 1'b0;
            r_sat_p1    <= 1'b0;
            r_satsel_p1 <= 1'b0;
            r_satovf_p1 <= 1'b0;
            r_vld_p1    <= 1'b0;
        end else begin
            r_sign_p1   <= x[31];
            r_mag_p1    <= w_dn[31:1];
            r_rb_p1     <= w_dn[0];
            r_sat_p1    <= w_sat;
            r_satsel_p1 <= x[31];
            r_satovf_p1 <= w_sat & ~w_min_int;
            r_vld_p1    <= in_valid;
        end
    end

    // Stage 2: round, apply sign, saturate
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_y_p2   <= '0;
            r_ovf_p2 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_y_p2   <= r_sat_p1 ? f_saturate(r_satsel_p1) : f_round(r_sign_p1, r_mag_p1, r_rb_p1);
            r_ovf_p2 <= r_satovf_p1;
            r_vld_p2 <= r_vld_p1;
        end
    end

    assign y         = r_y_p2;
    assign ovf       = r_ovf_p2;
    assign out_valid = r_vld_p2;

endmodule

// File: tb/tb_ftoi.sv
// Self-checking bench for ftoi: real-valued reference model, scoreboard queue,
// directed rounding/saturation/streaming/reset cases plus randomized traffic.
module tb_ftoi;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x = '0;
    logic        in_valid = 1'b0;
    logic [31:0] y;
    logic        out_valid;
    logic        ovf;

    ftoi dut (
        .clk      (clk),
        .rstn     (rstn),
        .x        (x),
        .in_valid (in_valid),
        .y        (y),
        .out_valid(out_valid),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: evaluate the float as a real number, round half away from zero, clamp.
    function automatic logic [32:0] model(input logic [31:0] xv);
        int     e;
        real    a;
        longint r;
        logic   s;
        logic [31:0] yv;
        s = xv[31];
        e = int'(xv[30:23]);
        if (e == 255) return {1'b1, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
        if (e == 0) begin
            a = real'(xv[22:0]);
            for (int i = 0; i < 149; i++) a = a / 2.0;
        end else begin
            a = real'({1'b1, xv[22:0]});
            if (e > 150) for (int i = 0; i < e - 150; i++) a = a * 2.0;
            else for (int i = 0; i < 150 - e; i++) a = a / 2.0;
        end
        if (a > 2147483648.0) return {1'b1, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
        if (a == 2147483648.0) return s ? {1'b0, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
        r  = longint'($floor(a + 0.5));
        yv = 32'(s ? -r : r);
        return {1'b0, yv};
    endfunction

    typedef struct {
        int          due;
        logic [31:0] y;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    logic rst_edge = 1'b0;

    always @(posedge clk) begin
        logic [32:0] m;
        cyc = cyc + 1;
        if (!rstn) begin
            q.delete();
            rst_edge = 1'b1;
        end else begin
            rst_edge = 1'b0;
            if (in_valid) begin
                m = model(x);
                q.push_back('{due: cyc + 1, y: m[31:0], ovf: m[32]});
            end
        end
    end

    always @(negedge clk) begin
        tests++;
        if (rst_edge) begin
            if (out_valid !== 1'b0 || y !== 32'h0 || ovf !== 1'b0) begin
                fails++;
                $display("FAIL reset_state edge %0d: got vld=%b y=%h ovf=%b, want vld=0 y=00000000 ovf=0",
                         cyc, out_valid, y, ovf);
            end
        end else if (q.size() != 0 && q[0].due == cyc) begin
            if (out_valid !== 1'b1 || y !== q[0].y || ovf !== q[0].ovf) begin
                fails++;
                $display("FAIL result edge %0d: got vld=%b y=%h ovf=%b, want vld=1 y=%h ovf=%b",
                         cyc, out_valid, y, ovf, q[0].y, q[0].ovf);
            end
            void'(q.pop_front());
        end else if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bubble edge %0d: got vld=%b, want vld=0", cyc, out_valid);
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic rn);
        @(negedge clk);
        in_valid = v;
        x        = d;
        rstn     = rn;
    endtask

    logic [31:0] lit_x   [17] = '{32'h3FC00000, 32'hBFC00000, 32'h3F000000, 32'h3FFFFFFF,
                                  32'h3EFFFFFF, 32'h80000000, 32'h00000001, 32'hBE800000,
                                  32'h4B7FFFFF, 32'h4B000001, 32'h4EFFFFFF, 32'hCEFFFFFF,
                                  32'h4F000000, 32'hCF000000, 32'hCF000001, 32'h7F800000,
                                  32'hFFC00000};
    logic [31:0] lit_y   [17] = '{32'h00000002, 32'hFFFFFFFE, 32'h00000001, 32'h00000002,
                                  32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h00FFFFFF, 32'h00800001, 32'h7FFFFF80, 32'h80000080,
                                  32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
                                  32'h80000000};
    logic        lit_ovf [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [32:0] m;
        logic [31:0] rx;
        // Pin the model to hand-computed values.
        for (int i = 0; i < 17; i++) begin
            m = model(lit_x[i]);
            tests++;
            if (m[31:0] !== lit_y[i] || m[32] !== lit_ovf[i]) begin
                fails++;
                $display("FAIL model_lit x=%h: got y=%h ovf=%b, want y=%h ovf=%b",
                         lit_x[i], m[31:0], m[32], lit_y[i], lit_ovf[i]);
            end
        end

        // Reset with in_valid held high: nothing may emerge.
        in_valid = 1'b1;
        x        = 32'h3F800000;
        repeat (3) @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);

        // Directed vectors back to back.
        for (int i = 0; i < 17; i++) drive(1'b1, lit_x[i], 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);

        // Streaming with one bubble.
        drive(1'b1, 32'h3F800000, 1'b1);
        drive(1'b1, 32'h40000000, 1'b1);
        drive(1'b1, 32'h40400000, 1'b1);
        drive(1'b1, 32'hC0800000, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h40A00000, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);

        // Reset mid-stream on the edge sampling 9.0.
        drive(1'b1, 32'h40E00000, 1'b1);
        drive(1'b1, 32'h41000000, 1'b1);
        drive(1'b1, 32'h41100000, 1'b0);
        drive(1'b1, 32'h41200000, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);

        // Randomized traffic, biased toward the interesting exponent band.
        for (int n = 0; n < 3000; n++) begin
            rx = $urandom;
            if ($urandom_range(0, 3) != 0) rx[30:23] = 8'($urandom_range(118, 162));
            drive(($urandom_range(0, 3) != 0), rx, ($urandom_range(0, 199) != 0));
        end

        drive(1'b0, 32'h0, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d results outstanding, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
